// File: rtl/fetch_queue.sv
// Purpose : instruction fetch stage; issues word addresses, tracks the 1-cycle memory read, queues {pc, inst}.
// Latency : issue-to-visible 2 edges (1 cycle combinational bypass when FETCH_BYPASS_EN is defined).
// Backpr. : issue stalls when queued + in-flight words reach DEPTH, so a returning word always has a slot.
//
// Ports:
//   clk, rst            single clock; asynchronous active-low reset
//   imem_addr           word address to instruction memory (straight from the pc register)
//   imem_data           memory read data, valid the cycle after imem_addr is sampled
//   redirect/redirect_pc  flush and restart fetch at redirect_pc (highest priority)
//   inst_valid/inst_ready/inst_data/inst_pc  head-of-queue handshake to decode; data/pc are 0 when not valid
//
// Optional feature: define FETCH_BYPASS_EN to present a returning word directly when the queue is empty.
module fetch_queue #(
    parameter int            AW       = 16,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_q, pc_d;
    logic          inf_q, inf_d;
    logic [AW-1:0] inf_pc_q, inf_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] fifo_pc_q  [DEPTH];
    logic [DW-1:0] fifo_dat_q [DEPTH];

    logic          has_data;
    logic          byp_vld;
    logic          byp_take;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;

    always_comb begin
        has_data = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        // Word arriving from memory into an empty queue is shown to decode in the same cycle.
        byp_vld  = !has_data && inf_q && !redirect;
`else
        byp_vld  = 1'b0;
`endif
        byp_take = byp_vld && inst_ready;

        inst_valid = (has_data && !redirect) || byp_vld;
        inst_data  = '0;
        inst_pc    = '0;
        if (has_data && !redirect) begin
            inst_data = fifo_dat_q[rd_ptr_q];
            inst_pc   = fifo_pc_q[rd_ptr_q];
        end else if (byp_vld) begin
            inst_data = imem_data;
            inst_pc   = inf_pc_q;
        end

        pop  = has_data && !redirect && inst_ready;
        // A bypassed word that decode takes never enters the queue.
        push = inf_q && !redirect && !byp_take;

        // Credit counts the in-flight word but not a same-cycle pop, so a push never meets a full queue.
        occupancy = {1'b0, count_q} + (CW+1)'(inf_q);
        issue     = !redirect && (occupancy < (CW+1)'(DEPTH));
    end

    always_comb begin
        pc_d     = pc_q;
        inf_d    = 1'b0;
        inf_pc_d = inf_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            // Flush: the in-flight word is dropped by clearing inf.
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + AW'(1);
                inf_d    = 1'b1;
                inf_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            inf_q    <= 1'b0;
            inf_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            inf_q    <= inf_d;
            inf_pc_q <= inf_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: count_q alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]  <= inf_pc_q;
            fifo_dat_q[wr_ptr_q] <= imem_data;
        end
    end

    assign imem_addr = pc_q;

endmodule
